ising_energy_monitor: RTL

Per-core energy monitor for an Ising core. After a spin configuration is latched, it consumes a stream of J-coupling rows with the matching H field and computes the total Ising energy E = -Σ_i s_i·(Σ_j J_ij·s_j + h_i). It sits directly downstream of the core's L1 J/flip memory readout and reports the result to the core's register slave.

---
 rtl/ising_energy_monitor.sv | 104 ++++++++++
 1 files changed

// File: rtl/ising_energy_monitor.sv
// Ising energy monitor: streams J rows against a latched spin vector and
// accumulates E = -sum_i s_i * (sum_j J_ij * s_j + h_i) through a 2-stage pipeline.
module ising_energy_monitor #(
  parameter int NumSpin        = 256,
  parameter int BitJ           = 4,
  parameter int BitH           = 4,
  parameter int EnergyTotalBit = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic [NumSpin-1:0]          spin_i,
  input  logic                        j_valid_i,
  output logic                        j_ready_o,
  input  logic [NumSpin*BitJ-1:0]     j_row_i,
  input  logic [BitH-1:0]             h_i,
  output logic                        busy_o,
  output logic                        energy_valid_o,
  input  logic                        energy_ready_i,
  output logic [EnergyTotalBit-1:0]   energy_o
);

  localparam int CntW = (NumSpin > 1) ? $clog2(NumSpin) : 1;
  localparam int TW   = BitJ + 1;
  localparam int RsW  = BitJ + 1 + $clog2(NumSpin + 1);
  localparam logic [CntW-1:0] LastRow = CntW'(NumSpin - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e                             state;
  logic [NumSpin-1:0]                 spin_q;
  logic [CntW-1:0]                    row_q;
  logic                               s1_valid;
  logic                               s1_spin;
  logic signed [RsW-1:0]              s1_rowsum;
  logic signed [RsW-1:0]              rowsum;
  logic signed [EnergyTotalBit-1:0]   acc;
  logic signed [EnergyTotalBit-1:0]   energy_q;
  logic signed [EnergyTotalBit-1:0]   rowsum_ext;
  logic signed [BitH-1:0]             h_s;
  logic signed [BitJ-1:0]             jv_c;
  logic signed [TW-1:0]               t_c;
  logic                               beat;

  assign beat           = j_valid_i && (state == RUN);
  assign j_ready_o      = (state == RUN);
  assign busy_o         = (state == RUN) || (state == DRAIN);
  assign energy_valid_o = (state == DONE);
  assign energy_o       = (state == DONE) ? acc : energy_q;
  assign h_s            = h_i;
  assign rowsum_ext     = EnergyTotalBit'(s1_rowsum);

  // One extra bit on each term so that negating the most negative J is exact.
  always_comb begin
    jv_c   = '0;
    t_c    = '0;
    rowsum = RsW'(h_s);
    for (int unsigned j = 0; j < NumSpin; j++) begin
      jv_c = j_row_i[j*BitJ +: BitJ];
      t_c  = TW'(jv_c);
      if (!spin_q[j]) t_c = -t_c;
      rowsum = rowsum + RsW'(t_c);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      spin_q    <= '0;
      row_q     <= '0;
      s1_valid  <= 1'b0;
      s1_spin   <= 1'b0;
      s1_rowsum <= '0;
      acc       <= '0;
      energy_q  <= '0;
    end else begin
      s1_valid <= beat;
      if (beat) begin
        s1_rowsum <= rowsum;
        s1_spin   <= spin_q[row_q];
        row_q     <= row_q + 1'b1;
      end
      if (s1_valid) acc <= s1_spin ? acc - rowsum_ext : acc + rowsum_ext;
      if (state == DONE) energy_q <= acc;

      case (state)
        RUN:     if (beat && row_q == LastRow) state <= DRAIN;
        DRAIN:   state <= DONE;
        DONE:    if (energy_ready_i) state <= IDLE;
        default: ;
      endcase

      // Placed last so an accepted start overrides a simultaneous handshake.
      if (start_i && (state == IDLE || state == DONE)) begin
        state    <= RUN;
        spin_q   <= spin_i;
        row_q    <= '0;
        acc      <= '0;
        s1_valid <= 1'b0;
      end
    end
  end

endmodule
